// File: rtl/mac_if_pkg.sv
// Shared MAC receive-path constants, state encoding and framer sizing.
package mac_if_pkg;

  localparam int unsigned GMII_DATA_W = 8;

  localparam logic [GMII_DATA_W-1:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [GMII_DATA_W-1:0] SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // The delay line holds exactly the FCS plus the byte being released.
  localparam int unsigned FRAMER_DEPTH = 5;
  localparam int unsigned FRAMER_OCC_W = 3;
  localparam int unsigned FRAMER_LEN_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    PAYLOAD,
    DROP
  } framer_state_t;

endpackage

// File: rtl/gmii_if.sv
// SDR GMII byte stream as produced by the RGMII DDR-to-SDR stage.
interface gmii_if;
  logic [mac_if_pkg::GMII_DATA_W-1:0] data;
  logic                               valid;
  logic                               error;

  modport master (output data, valid, error);
  modport slave  (input  data, valid, error);
endinterface

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 step, reflected polynomial, LSB first.
module crc32_d8
  import mac_if_pkg::*;
(
  input  logic [31:0]            crc_i,
  input  logic [GMII_DATA_W-1:0] data_i,
  output logic [31:0]            crc_o
);

  always_comb begin
    logic [31:0] c;
    c = crc_i;
    for (int i = 0; i < GMII_DATA_W; i++) begin
      c = (c[0] ^ data_i[i]) ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, hides the FCS behind a 5-byte delay line
// and gives each frame a good/bad verdict from CRC-32, RX_ER and length.
module gmii_rx_framer
  import mac_if_pkg::*;
#(
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1522
) (
  input  logic                   clk,
  input  logic                   rst_n,
  gmii_if.slave                  gmii_if_rx_i,
  output logic [GMII_DATA_W-1:0] m_data_o,
  output logic                   m_valid_o,
  output logic                   m_last_o,
  output logic                   m_user_o,
  output logic                   frame_good_o,
  output logic                   frame_bad_o
);

  localparam logic [FRAMER_OCC_W-1:0] OCC_FULL = FRAMER_OCC_W'(FRAMER_DEPTH);
  localparam logic [FRAMER_LEN_W-1:0] MIN_LEN  = FRAMER_LEN_W'(MIN_FRAME_LEN);
  localparam logic [FRAMER_LEN_W-1:0] MAX_LEN  = FRAMER_LEN_W'(MAX_FRAME_LEN);

  logic                   rx_dv;
  logic                   rx_er;
  logic [GMII_DATA_W-1:0] rx_data;

  // error carries RX_DV ^ RX_ER, so undo the XOR to recover RX_ER.
  assign rx_dv   = gmii_if_rx_i.valid;
  assign rx_er   = gmii_if_rx_i.valid ^ gmii_if_rx_i.error;
  assign rx_data = gmii_if_rx_i.data;

  framer_state_t                             state_q, state_d;
  logic [31:0]                               crc_q, crc_d, crc_next;
  logic [FRAMER_LEN_W-1:0]                   len_q, len_d;
  logic                                      err_q, err_d;
  logic [FRAMER_OCC_W-1:0]                   occ_q, occ_d;
  logic [FRAMER_DEPTH-1:0][GMII_DATA_W-1:0]  sr_q;
  logic                                      shift_en;
  logic                                      frame_bad;

  logic [GMII_DATA_W-1:0] m_data_q, m_data_d;
  logic                   m_valid_q, m_valid_d;
  logic                   m_last_q, m_last_d;
  logic                   m_user_q, m_user_d;
  logic                   good_q, good_d;
  logic                   bad_q, bad_d;

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (rx_data),
    .crc_o  (crc_next)
  );

  assign frame_bad = err_q | (crc_q != CRC32_RESIDUE) | (len_q < MIN_LEN) | (len_q > MAX_LEN);

  // NOTE: every variable is given a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    err_d     = err_q;
    occ_d     = occ_q;
    shift_en  = 1'b0;
    m_data_d  = '0;
    m_valid_d = 1'b0;
    m_last_d  = 1'b0;
    m_user_d  = 1'b0;
    good_d    = 1'b0;
    bad_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_dv) state_d = (rx_data == PREAMBLE_BYTE) ? PREAMBLE : DROP;
      end

      PREAMBLE: begin
        if (!rx_dv)                       state_d = IDLE;
        else if (rx_er)                   state_d = DROP;
        else if (rx_data == PREAMBLE_BYTE) state_d = PREAMBLE;
        else if (rx_data == SFD_BYTE) begin
          state_d = PAYLOAD;
          crc_d   = CRC32_INIT;
          len_d   = '0;
          err_d   = 1'b0;
          occ_d   = '0;
        end else                          state_d = DROP;
      end

      PAYLOAD: begin
        if (rx_dv) begin
          shift_en = 1'b1;
          crc_d    = crc_next;
          len_d    = (len_q == '1) ? len_q : len_q + FRAMER_LEN_W'(1);
          err_d    = err_q | rx_er;
          if (occ_q == OCC_FULL) begin
            m_valid_d = 1'b1;
            m_data_d  = sr_q[FRAMER_DEPTH-1];
          end else begin
            occ_d = occ_q + FRAMER_OCC_W'(1);
          end
        end else begin
          // Release the final data byte; the four FCS bytes behind it are discarded.
          state_d = IDLE;
          occ_d   = '0;
          if (occ_q == OCC_FULL) begin
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            m_user_d  = frame_bad;
            m_data_d  = sr_q[FRAMER_DEPTH-1];
            good_d    = !frame_bad;
            bad_d     = frame_bad;
          end else begin
            bad_d = 1'b1;
          end
        end
      end

      DROP: begin
        if (!rx_dv) state_d = IDLE;
      end

      default: state_d = DROP;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DROP;
      crc_q     <= CRC32_INIT;
      len_q     <= '0;
      err_q     <= 1'b0;
      occ_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_user_q  <= 1'b0;
      good_q    <= 1'b0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      err_q     <= err_d;
      occ_q     <= occ_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
    end
  end

  // NOTE: the delay line needs no reset; occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (shift_en) sr_q <= {sr_q[FRAMER_DEPTH-2:0], rx_data};
  end

  assign m_data_o     = m_data_q;
  assign m_valid_o    = m_valid_q;
  assign m_last_o     = m_last_q;
  assign m_user_o     = m_user_q;
  assign frame_good_o = good_q;
  assign frame_bad_o  = bad_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Self-checking bench: a frame-level reference model fills a per-cycle expectation table.
module tb_gmii_rx_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] m_data_o;
  logic       m_valid_o, m_last_o, m_user_o, frame_good_o, frame_bad_o;

  gmii_if rx ();

  gmii_rx_framer #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1522)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gmii_if_rx_i (rx),
    .m_data_o     (m_data_o),
    .m_valid_o    (m_valid_o),
    .m_last_o     (m_last_o),
    .m_user_o     (m_user_o),
    .frame_good_o (frame_good_o),
    .frame_bad_o  (frame_bad_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       valid;
    logic       last;
    logic       user;
    logic       good;
    logic       bad;
    logic [7:0] data;
  } exp_t;

  exp_t        exp_tab [int];
  logic [7:0]  bq [$];
  bit          eq [$];
  logic [31:0] crc_tbl [256];

  int n_cmp = 0, n_mis = 0;
  int n_bytes = 0, n_good = 0, n_bad = 0;
  int b0, g0, d0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_mis++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic void init_crc_tbl();
    for (int b = 0; b < 256; b++) begin
      logic [31:0] c;
      c = 32'(b);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[b] = c;
    end
  endfunction

  // Standard Ethernet CRC-32 (with final inversion) over bq[from +: cnt].
  function automatic logic [31:0] crc_over(input int from, input int cnt);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) c = (c >> 8) ^ crc_tbl[c[7:0] ^ bq[from+i]];
    return ~c;
  endfunction

  function automatic void put(input int key, input int lim, input exp_t e);
    if (lim < 0 || key <= lim) begin
      if (exp_tab.exists(key)) exp_tab[key] = exp_t'(exp_tab[key] | e);
      else                     exp_tab[key] = e;
    end
  endfunction

  // Frame-level rules: find the SFD, split payload from FCS, judge the frame,
  // and schedule each released byte the cycle after the byte five later is sampled.
  function automatic void run_model(input int s, input int lim);
    int   n, i, sfd, plen, lenm;
    logic bad;
    exp_t e;
    n = bq.size();
    if (n == 0 || bq[0] != 8'h55) return;
    i = 1;
    while (i < n && bq[i] == 8'h55 && !eq[i]) i++;
    if (i >= n || eq[i] || bq[i] != 8'hD5) return;
    sfd  = i;
    plen = n - sfd - 1;
    lenm = (plen > 2047) ? 2047 : plen;
    bad  = 1'b0;
    for (int j = sfd + 1; j < n; j++) if (eq[j]) bad = 1'b1;
    if (plen < 4) bad = 1'b1;
    else if ({bq[n-1], bq[n-2], bq[n-3], bq[n-4]} != crc_over(sfd + 1, plen - 4)) bad = 1'b1;
    if (lenm < 64 || lenm > 1522) bad = 1'b1;
    for (int k = 0; k <= plen - 6; k++) begin
      e = '0; e.valid = 1'b1; e.data = bq[sfd+1+k];
      put(s + sfd + 1 + k + 5 + 1, lim, e);
    end
    e = '0;
    if (plen >= 5) begin
      e.valid = 1'b1; e.last = 1'b1; e.user = bad; e.data = bq[n-5];
      e.good = !bad; e.bad = bad;
    end else begin
      e.bad = 1'b1;
    end
    put(s + n + 1, lim, e);
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input bit er);
    rx.valid = v;
    rx.data  = d;
    rx.error = v ^ er;
    @(posedge clk);
    #1;
  endtask

  task automatic build_good(input int ndata, input int npre);
    logic [31:0] fcs;
    bq.delete();
    eq.delete();
    repeat (npre) bq.push_back(8'h55);
    bq.push_back(8'hD5);
    for (int i = 0; i < ndata; i++) bq.push_back(8'($urandom));
    fcs = crc_over(npre + 1, ndata);
    for (int i = 0; i < 4; i++) bq.push_back(fcs[8*i +: 8]);
    for (int i = 0; i < bq.size(); i++) eq.push_back(1'b0);
  endtask

  task automatic send_burst(input int gap, input int rst_idx);
    int s, lim;
    s   = cyc;
    lim = (rst_idx >= 0) ? s + rst_idx : -1;
    run_model(s, lim);
    for (int i = 0; i < bq.size(); i++) begin
      if (i == rst_idx)     rst_n = 1'b0;
      if (i == rst_idx + 3) rst_n = 1'b1;
      drive(1'b1, bq[i], eq[i]);
    end
    rst_n = 1'b1;
    repeat (gap) drive(1'b0, 8'($urandom), 1'($urandom));
  endtask

  task automatic snap();
    b0 = n_bytes; g0 = n_good; d0 = n_bad;
  endtask

  task automatic expect_delta(input string name, input int bytes, input int good, input int bad);
    check({name, "_bytes"}, 64'(n_bytes - b0), 64'(bytes));
    check({name, "_good"},  64'(n_good - g0),  64'(good));
    check({name, "_bad"},   64'(n_bad - d0),   64'(bad));
  endtask

  task automatic compare_loop();
    exp_t        e;
    logic [12:0] got, want;
    forever begin
      @(negedge clk);
      e = exp_tab.exists(cyc) ? exp_tab[cyc] : exp_t'('0);
      if (m_valid_o === 1'b1)    n_bytes++;
      if (frame_good_o === 1'b1) n_good++;
      if (frame_bad_o === 1'b1)  n_bad++;
      want = {e.valid, e.last, e.good, e.bad, e.user, e.data};
      got  = {m_valid_o, m_last_o, frame_good_o, frame_bad_o,
              e.last ? m_user_o : 1'b0, e.valid ? m_data_o : 8'h00};
      check($sformatf("cyc%0d", cyc), 64'(got), 64'(want));
    end
  endtask

  initial begin
    init_crc_tbl();
    bq.delete();
    for (int i = 0; i < 9; i++) bq.push_back(8'(8'h31 + i));
    check("crc_model_pin", 64'(crc_over(0, 9)), 64'h00000000CBF43926);

    rst_n    = 1'b0;
    rx.valid = 1'b0;
    rx.data  = 8'h00;
    rx.error = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) drive(1'b0, 8'h00, 1'b0);
    check("reset_state", 64'({m_data_o, m_valid_o, m_last_o, m_user_o, frame_good_o, frame_bad_o}), 64'd0);
    rst_n = 1'b1;
    fork compare_loop(); join_none
    repeat (3) drive(1'b0, 8'h00, 1'b0);

    snap(); build_good(60, 7); send_burst(6, -1);
    expect_delta("good60", 60, 1, 0);

    snap(); build_good(60, 7); bq[8+17] ^= 8'h04; send_burst(6, -1);
    expect_delta("bitflip", 60, 0, 1);

    snap(); build_good(60, 7); eq[8+9] = 1'b1; send_burst(6, -1);
    expect_delta("rx_er", 60, 0, 1);

    snap();
    bq = '{8'h55, 8'h55, 8'h12, 8'h55, 8'hD5, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};
    eq.delete(); for (int i = 0; i < bq.size(); i++) eq.push_back(1'b0);
    send_burst(12, -1);
    expect_delta("bad_preamble", 0, 0, 0);
    snap(); build_good(60, 7); send_burst(6, -1);
    expect_delta("after_drop", 60, 1, 0);

    snap(); build_good(60, 7); send_burst(1, -1); build_good(70, 7); send_burst(6, -1);
    expect_delta("back2back", 130, 2, 0);

    snap(); build_good(60, 7); while (bq.size() > 8 + 3) begin void'(bq.pop_back()); void'(eq.pop_back()); end
    send_burst(6, -1);
    expect_delta("len3", 0, 0, 1);

    snap(); build_good(59, 7);   send_burst(6, -1); expect_delta("len63",   59,   0, 1);
    snap(); build_good(1518, 7); send_burst(6, -1); expect_delta("len1522", 1518, 1, 0);
    snap(); build_good(1519, 7); send_burst(6, -1); expect_delta("len1523", 1519, 0, 1);
    snap(); build_good(2096, 7); send_burst(6, -1); expect_delta("len2100", 2096, 0, 1);

    snap(); build_good(100, 7); send_burst(4, 38);
    expect_delta("reset_mid", 25, 0, 0);

    for (int f = 0; f < 40; f++) begin
      int kind, npre, nd;
      kind = $urandom_range(0, 9);
      npre = $urandom_range(1, 7);
      nd   = $urandom_range(60, 160);
      case (kind)
        0: begin
          build_good(nd, npre);
          if ($urandom_range(0, 1) == 0) begin
            bq[npre] = 8'($urandom);
            if (bq[npre] == 8'h55 || bq[npre] == 8'hD5) bq[npre] = 8'h12;
          end else begin
            eq[$urandom_range(1, npre)] = 1'b1;
          end
        end
        1: begin
          build_good(8, npre);
          nd = $urandom_range(0, 8);
          while (bq.size() > npre + 1 + nd) begin void'(bq.pop_back()); void'(eq.pop_back()); end
        end
        2: begin build_good(nd, npre); bq[npre+1+$urandom_range(0, nd+3)] ^= 8'(1 << $urandom_range(0, 7)); end
        3: begin build_good(nd, npre); eq[npre+1+$urandom_range(0, nd+3)] = 1'b1; end
        4: build_good($urandom_range(5, 59), npre);
        default: build_good(nd, npre);
      endcase
      send_burst($urandom_range(1, 6), -1);
    end

    repeat (8) drive(1'b0, 8'h00, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
